est_pipe_input_arbiter: RTL

- Sequences entry into the established-flow receive pipe. It arbitrates between new packets from the issue stage and packets from the FSM reinject queue.
- Reinject traffic normally has priority. A burst counter bounds how many reinject grants in a row can block a waiting issue packet.
- The winning packet goes into a single registered output stage with valid/ready handshake, full throughput, ahead of the est pipe.
- Per-source grant counters are exposed for debug and statistics.

---
 rtl/est_pipe_input_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/est_pipe_input_arbiter.sv
// Entry arbiter for the established-flow receive pipe. Picks between the issue
// stage and the FSM reinject queue and feeds one registered valid/ready output stage.
module est_pipe_input_arbiter #(
    parameter int REINJECT_BURST_MAX = 4,
    parameter int BURST_CNT_W        = 4,
    parameter int STAT_W             = 32,
    parameter int FLOWID_W           = 12,
    parameter int TCP_HDR_W          = 160,
    parameter int PAYLOAD_ENTRY_W    = 16,
    parameter int REINJECT_W         = TCP_HDR_W + FLOWID_W + 1 + PAYLOAD_ENTRY_W
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       issue_merger_est_hdr_val,
    input  logic [TCP_HDR_W-1:0]       issue_merger_est_tcp_hdr,
    input  logic [FLOWID_W-1:0]        issue_merger_est_flowid,
    input  logic                       issue_merger_est_payload_val,
    input  logic [PAYLOAD_ENTRY_W-1:0] issue_merger_est_payload_entry,
    output logic                       merger_issue_est_pipe_rdy,

    output logic                       merger_fsm_reinject_q_deq_req_val,
    input  logic [REINJECT_W-1:0]      fsm_reinject_q_merger_deq_resp_data,
    input  logic                       fsm_reinject_q_merger_empty,

    output logic                       est_hdr_val,
    output logic [TCP_HDR_W-1:0]       est_tcp_hdr,
    output logic [FLOWID_W-1:0]        est_flowid,
    output logic                       est_payload_val,
    output logic [PAYLOAD_ENTRY_W-1:0] est_payload_entry,
    input  logic                       est_pipe_rdy,

    output logic [STAT_W-1:0]          reinject_grant_cnt,
    output logic [STAT_W-1:0]          issue_grant_cnt,
    output logic [BURST_CNT_W-1:0]     burst_cnt
);

    // Handshake: a transfer happens on a rising edge where the producer's valid
    // and the consumer's ready are both high; ready never looks at valid.
    localparam logic [BURST_CNT_W-1:0] BURST_MAX = BURST_CNT_W'(REINJECT_BURST_MAX);

    // Reinject entry layout, MSB first: {tcp_hdr, flowid, payload_val, payload_entry}.
    logic [TCP_HDR_W-1:0]       r_tcp_hdr;
    logic [FLOWID_W-1:0]        r_flowid;
    logic                       r_payload_val;
    logic [PAYLOAD_ENTRY_W-1:0] r_payload_entry;

    assign {r_tcp_hdr, r_flowid, r_payload_val, r_payload_entry} =
        fsm_reinject_q_merger_deq_resp_data;

    logic load_en;
    logic req_r;
    logic req_i;
    logic force_issue;
    logic grant_r;
    logic grant_i;

    assign load_en     = ~est_hdr_val | est_pipe_rdy;
    assign req_r       = ~fsm_reinject_q_merger_empty;
    assign req_i       = issue_merger_est_hdr_val;
    assign force_issue = (burst_cnt == BURST_MAX);

    assign grant_r = load_en & req_r & ~(req_i & force_issue);
    assign grant_i = load_en & req_i & ~(req_r & ~force_issue);

    assign merger_fsm_reinject_q_deq_req_val = grant_r;
    // Issue ready is built from queue state only, so the issue stage may derive
    // its valid from it without forming a loop.
    assign merger_issue_est_pipe_rdy = load_en & (~req_r | force_issue);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            est_hdr_val <= 1'b0;
        end else if (load_en) begin
            est_hdr_val <= grant_r | grant_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            est_tcp_hdr       <= '0;
            est_flowid        <= '0;
            est_payload_val   <= 1'b0;
            est_payload_entry <= '0;
        end else if (grant_r) begin
            est_tcp_hdr       <= r_tcp_hdr;
            est_flowid        <= r_flowid;
            est_payload_val   <= r_payload_val;
            est_payload_entry <= r_payload_entry;
        end else if (grant_i) begin
            est_tcp_hdr       <= issue_merger_est_tcp_hdr;
            est_flowid        <= issue_merger_est_flowid;
            est_payload_val   <= issue_merger_est_payload_val;
            est_payload_entry <= issue_merger_est_payload_entry;
        end
    end

    // A streak only counts while issue is actually waiting behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= '0;
        end else if (grant_i) begin
            burst_cnt <= '0;
        end else if (grant_r) begin
            if (req_i) begin
                if (burst_cnt != BURST_MAX) begin
                    burst_cnt <= burst_cnt + BURST_CNT_W'(1);
                end
            end else begin
                burst_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reinject_grant_cnt <= '0;
            issue_grant_cnt    <= '0;
        end else begin
            if (grant_r) begin
                reinject_grant_cnt <= reinject_grant_cnt + STAT_W'(1);
            end
            if (grant_i) begin
                issue_grant_cnt <= issue_grant_cnt + STAT_W'(1);
            end
        end
    end

endmodule
